// File: rtl/usb_rx_ctrl.sv
// USB receive sequencer: NRZI decode, bit unstuffing, LSB-first byte assembly, EOP and error detection.
// Optional RX_BYTE_COUNT_EN adds rx_byte_count (bytes delivered in the current/last packet).
module usb_rx_ctrl #(
  parameter int EOP_SE0_MIN = 2,
  parameter int MAX_BYTES   = 1027,
  parameter int STUFF_LEN   = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  line_state,
  input  logic        sync_detected,
  output logic        rx_active,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_error,
`ifdef RX_BYTE_COUNT_EN
  output logic [10:0] rx_byte_count,
`endif
  output logic [1:0]  fsm_state
);

  // Handshake: rx_valid and rx_error are single-cycle strobes with no back-pressure;
  // rx_data is meaningful only in the cycle rx_valid is high, and the two never coincide.

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, EOP = 2'd2, ERR_WAIT = 2'd3} state_t;

  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b11;
  localparam logic [1:0] LS_ILL = 2'b00;

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [OW-1:0] STUFF_V   = OW'(STUFF_LEN);
  localparam logic [BW-1:0] MAX_V     = BW'(MAX_BYTES);
  localparam logic [2:0]    SE0_MIN_V = 3'(EOP_SE0_MIN);

  state_t        state, state_nxt;
  logic          sync_d;
  logic [1:0]    prev_line;
  logic [OW-1:0] ones_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    se0_cnt;
  logic [7:0]    shift_reg;

  logic          sop, in_data, is_jk, bit_val, stuff_hit, take_bit, byte_done, babble;
  logic [1:0]    ref_line;
  logic [OW-1:0] ones_base;
  logic [2:0]    bit_base;
  logic [BW-1:0] byte_base;
  logic          valid_nxt, error_nxt;

  // The start-of-packet cycle is itself data bit 0, decoded against K with the
  // trailing sync KK counted as one '1'; counters from a previous packet are ignored.
  always_comb begin
    sop       = (state == IDLE) && sync_detected && !sync_d;
    in_data   = sop || (state == DATA);
    is_jk     = (line_state == LS_J) || (line_state == LS_K);
    ref_line  = (state == IDLE) ? LS_K : prev_line;
    ones_base = (state == IDLE) ? OW'(1) : ones_cnt;
    bit_base  = (state == IDLE) ? 3'd0 : bit_cnt;
    byte_base = (state == IDLE) ? '0 : byte_cnt;
    bit_val   = (line_state == ref_line);
    stuff_hit = (ones_base == STUFF_V);
    take_bit  = in_data && is_jk && !stuff_hit;
    byte_done = take_bit && (bit_base == 3'd7);
    babble    = byte_done && (byte_base == MAX_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DATA: begin
        if (in_data) begin
          if (is_jk) begin
            if ((stuff_hit && bit_val) || babble) state_nxt = ERR_WAIT;
            else                                  state_nxt = DATA;
          end else if (line_state == LS_SE0) begin
            state_nxt = EOP;
          end else begin
            state_nxt = ERR_WAIT;
          end
        end
      end
      EOP: begin
        if (line_state == LS_J)        state_nxt = IDLE;
        else if (line_state != LS_SE0) state_nxt = ERR_WAIT;
      end
      ERR_WAIT: begin
        if (line_state == LS_J && se0_cnt != 3'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_active = (state != IDLE);
    fsm_state = state;
    valid_nxt = byte_done && !babble;
    error_nxt = 1'b0;
    if (in_data) begin
      error_nxt = (is_jk && stuff_hit && bit_val) || babble || (line_state == LS_ILL);
    end else if (state == EOP) begin
      if (line_state == LS_J)        error_nxt = (se0_cnt < SE0_MIN_V) || (bit_cnt != 3'd0);
      else if (line_state != LS_SE0) error_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d    <= 1'b0;
      prev_line <= LS_K;
      ones_cnt  <= '0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= '0;
      se0_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      sync_d   <= sync_detected;
      rx_valid <= valid_nxt;
      rx_error <= error_nxt;
      if (valid_nxt) rx_data <= {bit_val, shift_reg[7:1]};
      if (in_data) begin
        bit_cnt  <= bit_base;
        byte_cnt <= byte_base;
        ones_cnt <= ones_base;
        se0_cnt  <= (line_state == LS_SE0) ? 3'd1 : 3'd0;
        if (is_jk) begin
          prev_line <= line_state;
          if (stuff_hit) begin
            ones_cnt <= '0;
          end else begin
            ones_cnt  <= bit_val ? ones_base + OW'(1) : '0;
            shift_reg <= {bit_val, shift_reg[7:1]};
            bit_cnt   <= bit_base + 3'd1;
            if (byte_done) byte_cnt <= byte_base + BW'(1);
          end
        end
      end else if (state == IDLE) begin
        prev_line <= LS_K;
        se0_cnt   <= 3'd0;
      end else begin
        // EOP and ERR_WAIT both track a saturating SE0 run.
        if (line_state == LS_SE0) begin
          if (se0_cnt != 3'd7) se0_cnt <= se0_cnt + 3'd1;
        end else begin
          se0_cnt <= 3'd0;
        end
      end
    end
  end

`ifdef RX_BYTE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       rx_byte_count <= 11'd0;
    else if (sop)       rx_byte_count <= 11'd0;
    else if (valid_nxt) rx_byte_count <= rx_byte_count + 11'd1;
  end
`endif

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Receive sequencer for the USB PHY. It runs after the sync detector and takes over the line once sync completes. It NRZI-decodes the line state, removes stuffed bits, assembles LSB-first bytes, detects EOP, and flags stuff, line, alignment and babble errors. Outputs use a UTMI-style receive interface (rx_active/rx_valid/rx_data/rx_error) for the packet decoder.

Parameters:
EOP_SE0_MIN, 2, minimum consecutive SE0 samples before J for a valid EOP
MAX_BYTES, 1027, byte limit per packet; a byte beyond this is babble
STUFF_LEN, 6, number of consecutive ones that forces a stuffed zero

Ports:
clk  in  1  bit-rate clock; one line sample per cycle
reset_n  in  1  asynchronous, active-low reset
line_state  in  2  01=J, 10=K, 11=SE0, 00=illegal (same encoding as the sync detector)
sync_detected  in  1  level from the sync detector; high from the cycle after the final sync K until SE0
rx_active  out  1  packet reception in progress
rx_valid  out  1  one-cycle strobe; rx_data holds a complete byte
rx_data  out  8  received byte, LSB first on the wire
rx_error  out  1  one-cycle error strobe

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, rx_active=0, rx_valid=0, rx_data=8'h00, rx_error=0, all counters 0, prev_line=K.
- States: IDLE, DATA, EOP, ERR_WAIT (2-bit encoding).
- NRZI decode: bit=1 if line_state==prev_line, else 0. prev_line updates on every J/K sample in DATA.
- Start of packet: in IDLE, sync_detected high and sync_d (registered) low:
  - Go to DATA and set rx_active=1 on the next edge.
  - The line_state in that same cycle is data bit 0, decoded against prev_line=K.
  - ones_cnt starts at 1, because the trailing sync KK counts as one '1'.
- Start-of-packet qualifier: sync_detected high while not in IDLE is ignored. Only a rising edge in IDLE starts a packet.
- DATA, J/K sample:
  - If ones_cnt==STUFF_LEN and bit==0: stuffed bit. Discard it, ones_cnt=0.
  - If ones_cnt==STUFF_LEN and bit==1: stuff error. rx_error=1, go to ERR_WAIT.
  - Otherwise shift the bit into the MSB of the shift register, bit_cnt++, and set ones_cnt = bit ? ones_cnt+1 : 0.
  - When bit_cnt reaches 8: rx_data=shift value and rx_valid=1 on the next edge (latency: 1 cycle after the 8th bit sample). Then bit_cnt=0 and byte_cnt++.
- Babble: a byte completing with byte_cnt==MAX_BYTES sets rx_error instead of rx_valid and goes to ERR_WAIT.
- DATA, SE0 sample: go to EOP, se0_cnt=1.
- DATA, 00 sample: rx_error, go to ERR_WAIT.
- EOP:
  - SE0: se0_cnt++, saturating at 3 bits.
  - J with se0_cnt>=EOP_SE0_MIN and bit_cnt==0: go to IDLE, rx_active=0 next edge, no error.
  - J with se0_cnt<EOP_SE0_MIN or bit_cnt!=0 (partial byte): rx_error pulse, go to IDLE, rx_active=0.
  - K or 00: rx_error, go to ERR_WAIT.
- ERR_WAIT: rx_active stays 1 and no rx_valid. Leave on an SE0 sample followed by a J sample, then go to IDLE with rx_active=0. rx_error pulses only on entry to ERR_WAIT.
- Precedence: rx_valid and rx_error are never high in the same cycle; an error discards any pending byte.
- Reset mid-packet: all outputs drop immediately. Because sync_d is cleared, a still-high sync_detected after reset starts a new packet.

Optional Feature:
RX_BYTE_COUNT_EN:
- Defined: adds output rx_byte_count[10:0], the number of bytes delivered in the current/last packet.
  - Clears to 0 at start of packet.
  - Increments with each rx_valid.
  - Holds its value after EOP.
  - Reset value 0.
- Undefined: port and counter absent, except the internal byte_cnt needed for the babble check.

Test Plan:
1. Sync, then J,K,J,K,J,K,J,K (byte 0x00), SE0,SE0,J -> one rx_valid with rx_data=8'h00; rx_active falls the cycle after J; rx_error never asserted.
2. Sync, then K,K,K,K,K,J(stuff),J,J,J, SE0,SE0,J -> rx_data=8'hFF, a single rx_valid; the stuffed J is not counted.
3. Sync, then K×6 (six ones, seven with sync) -> rx_error pulse at the 6th sample; rx_active stays high until SE0 then J; no rx_valid.
4. Sync, 0x00 byte, 3 extra data bits, SE0,SE0,J -> one rx_valid (0x00), then an rx_error pulse at J; rx_active=0 afterwards.
5. Assert reset_n=0 mid-byte (bit_cnt=4) -> rx_active/rx_valid/rx_error=0 immediately, state=IDLE. With sync_detected held high after release -> new packet starts.
6. MAX_BYTES=2: sync, three 0x00 bytes -> two rx_valid pulses, rx_error on the third byte, and (with RX_BYTE_COUNT_EN) rx_byte_count=2.
